// File: rtl/hazard_ctrl_if.sv
// Bundles the pipeline-side hazard inputs and stage-register controls for hazard_ctrl.
// The pipeline side is the master; the controller connects through the slave modport.
interface hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             MemRead_EX;
    logic [4:0]       Rt_EX;
    logic [4:0]       Rs_ID;
    logic [4:0]       Rt_ID;
    logic             UsesRt_ID;
    logic             BranchTaken_EX;
    logic             MulDivStart_EX;
    logic             PCWrite;
    logic             IF_ID_Write;
    logic             IF_ID_Flush;
    logic             ID_EX_Flush;
    logic             EX_Hold;
    logic             MulDivDone;
    logic             Busy;
    logic [CNT_W-1:0] StallCount;

    modport master (
        output MemRead_EX, Rt_EX, Rs_ID, Rt_ID, UsesRt_ID, BranchTaken_EX, MulDivStart_EX,
        input  PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, EX_Hold, MulDivDone, Busy, StallCount
    );

    modport slave (
        input  MemRead_EX, Rt_EX, Rs_ID, Rt_ID, UsesRt_ID, BranchTaken_EX, MulDivStart_EX,
        output PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, EX_Hold, MulDivDone, Busy, StallCount
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS pipeline: load-use stalls, taken-branch squash,
// fixed-latency mul/div freeze and a saturating stall-cycle counter. Outputs are Mealy.
module hazard_ctrl #(
    parameter int MD_CYCLES = 4,
    parameter int CNT_W     = 16
) (
    input  logic          Clk,
    input  logic          Rst,
    hazard_ctrl_if.slave  bus
);
    localparam logic [0:0] RUN     = 1'b0;
    localparam logic [0:0] MD_BUSY = 1'b1;
    localparam logic [7:0] MD_LOAD = 8'(MD_CYCLES - 1);

    logic [0:0]       r_state;
    logic [0:0]       w_state_next;
    logic [7:0]       r_cnt;
    logic [7:0]       w_cnt_next;
    logic             r_just_done;
    logic             w_just_done_next;
    logic [CNT_W-1:0] r_stall_cnt;

    logic w_hazard;
    logic w_pc_write;
    logic w_if_id_write;
    logic w_if_id_flush;
    logic w_id_ex_flush;
    logic w_ex_hold;
    logic w_md_done;
    logic w_busy;

    // $zero is never a real producer, so it can never cause a stall.
    assign w_hazard = bus.MemRead_EX && (bus.Rt_EX != 5'd0) &&
                      ((bus.Rt_EX == bus.Rs_ID) || (bus.UsesRt_ID && (bus.Rt_EX == bus.Rt_ID)));

    always_comb begin
        w_pc_write       = 1'b1;
        w_if_id_write    = 1'b1;
        w_if_id_flush    = 1'b0;
        w_id_ex_flush    = 1'b0;
        w_ex_hold        = 1'b0;
        w_md_done        = 1'b0;
        w_busy           = 1'b0;
        w_state_next     = r_state;
        w_cnt_next       = r_cnt;
        w_just_done_next = 1'b0;

        if (Rst) begin
            w_pc_write    = 1'b0;
            w_if_id_write = 1'b0;
        end else if (r_state == MD_BUSY) begin
            w_pc_write    = 1'b0;
            w_if_id_write = 1'b0;
            w_ex_hold     = 1'b1;
            w_busy        = 1'b1;
            w_cnt_next    = r_cnt - 8'd1;
            if (r_cnt == 8'd1) begin
                w_md_done        = 1'b1;
                w_state_next     = RUN;
                w_just_done_next = 1'b1;
            end
        end else begin
            if (bus.BranchTaken_EX) begin
                w_if_id_flush = 1'b1;
                w_id_ex_flush = 1'b1;
            end else if (bus.MulDivStart_EX && !r_just_done) begin
                // The held mul/div is still in EX right after completion; r_just_done blocks a re-start.
                w_pc_write    = 1'b0;
                w_if_id_write = 1'b0;
                w_ex_hold     = 1'b1;
                w_cnt_next    = MD_LOAD;
                w_state_next  = MD_BUSY;
            end else if (w_hazard) begin
                w_pc_write    = 1'b0;
                w_if_id_write = 1'b0;
                w_id_ex_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state     <= RUN;
            r_cnt       <= 8'd0;
            r_just_done <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_just_done <= w_just_done_next;
            if (!w_pc_write && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.PCWrite     = w_pc_write;
    assign bus.IF_ID_Write = w_if_id_write;
    assign bus.IF_ID_Flush = w_if_id_flush;
    assign bus.ID_EX_Flush = w_id_ex_flush;
    assign bus.EX_Hold     = w_ex_hold;
    assign bus.MulDivDone  = w_md_done;
    assign bus.Busy        = w_busy;
    assign bus.StallCount  = r_stall_cnt;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic against a
// behavioural model; a second instance with CNT_W=4 exercises counter saturation.
module tb_hazard_ctrl;
    localparam int MDC = 4;

    logic Clk = 1'b0;
    logic Rst;
    always #5 Clk = ~Clk;

    hazard_ctrl_if #(.CNT_W(16)) bus16 ();
    hazard_ctrl_if #(.CNT_W(4))  bus4 ();

    hazard_ctrl #(.MD_CYCLES(MDC), .CNT_W(16)) u_dut (.Clk(Clk), .Rst(Rst), .bus(bus16.slave));
    hazard_ctrl #(.MD_CYCLES(MDC), .CNT_W(4))  u_sat (.Clk(Clk), .Rst(Rst), .bus(bus4.slave));

    logic       mem_read, uses_rt, br, md;
    logic [4:0] rt_ex, rs_id, rt_id;

    assign bus16.MemRead_EX = mem_read;     assign bus4.MemRead_EX = mem_read;
    assign bus16.Rt_EX = rt_ex;             assign bus4.Rt_EX = rt_ex;
    assign bus16.Rs_ID = rs_id;             assign bus4.Rs_ID = rs_id;
    assign bus16.Rt_ID = rt_id;             assign bus4.Rt_ID = rt_id;
    assign bus16.UsesRt_ID = uses_rt;       assign bus4.UsesRt_ID = uses_rt;
    assign bus16.BranchTaken_EX = br;       assign bus4.BranchTaken_EX = br;
    assign bus16.MulDivStart_EX = md;       assign bus4.MulDivStart_EX = md;

    // Model: hold cycles still owed by an op in progress, the "op just finished" flag, stall totals.
    int m_left, m_cnt16, m_cnt4;
    bit m_jd;
    int n_cmp = 0;
    int n_bad = 0;

    // Output vector order: PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, EX_Hold, MulDivDone, Busy.
    function automatic logic [6:0] outs16();
        return {bus16.PCWrite, bus16.IF_ID_Write, bus16.IF_ID_Flush, bus16.ID_EX_Flush,
                bus16.EX_Hold, bus16.MulDivDone, bus16.Busy};
    endfunction

    function automatic logic [6:0] outs4();
        return {bus4.PCWrite, bus4.IF_ID_Write, bus4.IF_ID_Flush, bus4.ID_EX_Flush,
                bus4.EX_Hold, bus4.MulDivDone, bus4.Busy};
    endfunction

    function automatic bit model_hazard();
        return mem_read && rt_ex != 0 && (rt_ex == rs_id || (uses_rt && rt_ex == rt_id));
    endfunction

    function automatic logic [6:0] exp_outs();
        if (Rst) return 7'b0000000;
        if (m_left > 0) return {4'b0000, 1'b1, (m_left == 1), 1'b1};
        if (br) return 7'b1111000;
        if (md && !m_jd) return 7'b0000100;
        if (model_hazard()) return 7'b0001000;
        return 7'b1100000;
    endfunction

    task automatic model_reset();
        m_left = 0; m_jd = 0; m_cnt16 = 0; m_cnt4 = 0;
    endtask

    task automatic set_idle();
        mem_read = 0; rt_ex = 0; rs_id = 0; rt_id = 0; uses_rt = 0; br = 0; md = 0;
    endtask

    // One clock edge: the model consumes the pre-edge outputs, then returns at the next falling edge.
    task automatic tick();
        logic [6:0] e;
        e = exp_outs();
        @(posedge Clk);
        if (!Rst) begin
            if (!e[6]) begin
                if (m_cnt16 < 65535) m_cnt16++;
                if (m_cnt4 < 15) m_cnt4++;
            end
            m_jd = (m_left == 1);
            if (m_left > 0) m_left--;
            else if (e[2]) m_left = MDC - 1;
        end
        @(negedge Clk);
    endtask

    task automatic test_reset();
        Rst = 1'b1; set_idle(); model_reset();
        #1;
        n_cmp++;
        if (outs16() !== 7'b0000000) begin
            n_bad++; $display("FAIL reset_outs got=%b exp=%b", outs16(), 7'b0000000);
        end
        @(posedge Clk); @(negedge Clk);
        n_cmp++;
        if (bus16.StallCount !== 16'd0) begin
            n_bad++; $display("FAIL reset_count got=%0d exp=0", bus16.StallCount);
        end
        Rst = 1'b0;
        #1;
        n_cmp++;
        if (outs16() !== 7'b1100000) begin
            n_bad++; $display("FAIL reset_release got=%b exp=%b", outs16(), 7'b1100000);
        end
        $display("test_reset: outs=%b count=%0d", outs16(), bus16.StallCount);
        @(negedge Clk);
    endtask

    task automatic test_load_use();
        int base;
        base = m_cnt16;
        mem_read = 1; rt_ex = 5'd8; rs_id = 5'd8; rt_id = 5'd3;
        #1;
        n_cmp++;
        if (outs16() !== 7'b0001000) begin
            n_bad++; $display("FAIL load_use_stall got=%b exp=%b", outs16(), 7'b0001000);
        end
        tick();
        set_idle();
        #1;
        n_cmp++;
        if (outs16() !== 7'b1100000) begin
            n_bad++; $display("FAIL load_use_clear got=%b exp=%b", outs16(), 7'b1100000);
        end
        n_cmp++;
        if (bus16.StallCount !== 16'(base + 1)) begin
            n_bad++; $display("FAIL load_use_count got=%0d exp=%0d", bus16.StallCount, base + 1);
        end
        $display("test_load_use: count=%0d", bus16.StallCount);
        tick();
    endtask

    task automatic test_zero_reg();
        int base;
        base = m_cnt16;
        mem_read = 1; rt_ex = 5'd0; rs_id = 5'd0; rt_id = 5'd0; uses_rt = 1;
        #1;
        n_cmp++;
        if (outs16() !== 7'b1100000) begin
            n_bad++; $display("FAIL zero_reg_outs got=%b exp=%b", outs16(), 7'b1100000);
        end
        tick();
        n_cmp++;
        if (bus16.StallCount !== 16'(base)) begin
            n_bad++; $display("FAIL zero_reg_count got=%0d exp=%0d", bus16.StallCount, base);
        end
        $display("test_zero_reg: outs=%b count=%0d", outs16(), bus16.StallCount);
        set_idle();
    endtask

    task automatic test_branch_hazard();
        int base;
        base = m_cnt16;
        br = 1; mem_read = 1; rt_ex = 5'd9; rt_id = 5'd9; uses_rt = 1; rs_id = 5'd1;
        #1;
        n_cmp++;
        if (outs16() !== 7'b1111000) begin
            n_bad++; $display("FAIL branch_outs got=%b exp=%b", outs16(), 7'b1111000);
        end
        tick();
        n_cmp++;
        if (bus16.StallCount !== 16'(base)) begin
            n_bad++; $display("FAIL branch_count got=%0d exp=%0d", bus16.StallCount, base);
        end
        $display("test_branch_hazard: count=%0d", bus16.StallCount);
        set_idle();
    endtask

    task automatic test_muldiv();
        logic [6:0] exp_tab [5];
        int base;
        exp_tab[0] = 7'b0000100; exp_tab[1] = 7'b0000101; exp_tab[2] = 7'b0000101;
        exp_tab[3] = 7'b0000111; exp_tab[4] = 7'b1100000;
        base = m_cnt16;
        md = 1;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_cmp++;
            if (outs16() !== exp_tab[c]) begin
                n_bad++; $display("FAIL muldiv_cycle%0d got=%b exp=%b", c, outs16(), exp_tab[c]);
            end
            $display("test_muldiv: cycle %0d outs=%b", c, outs16());
            tick();
        end
        n_cmp++;
        if (bus16.StallCount !== 16'(base + 4)) begin
            n_bad++; $display("FAIL muldiv_count got=%0d exp=%0d", bus16.StallCount, base + 4);
        end
        md = 0;
        tick();
    endtask

    task automatic test_back_to_back();
        int base;
        base = m_cnt16;
        mem_read = 1; rt_ex = 5'd5; rs_id = 5'd5; rt_id = 5'd6; uses_rt = 1;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_cmp++;
            if (outs16() !== 7'b0001000) begin
                n_bad++; $display("FAIL b2b_stall%0d got=%b exp=%b", c, outs16(), 7'b0001000);
            end
            tick();
            rt_ex = 5'd6;   // second load now in EX, feeding the same consumer's rt
        end
        set_idle();
        n_cmp++;
        if (bus16.StallCount !== 16'(base + 2)) begin
            n_bad++; $display("FAIL b2b_count got=%0d exp=%0d", bus16.StallCount, base + 2);
        end
        $display("test_back_to_back: count=%0d", bus16.StallCount);
    endtask

    task automatic test_reset_mid_op();
        md = 1;
        tick(); tick();
        #1;
        n_cmp++;
        if (outs16() !== 7'b0000101) begin
            n_bad++; $display("FAIL midop_busy got=%b exp=%b", outs16(), 7'b0000101);
        end
        #1 Rst = 1'b1; model_reset();
        #1;
        n_cmp++;
        if (outs16() !== 7'b0000000) begin
            n_bad++; $display("FAIL midop_reset_outs got=%b exp=%b", outs16(), 7'b0000000);
        end
        n_cmp++;
        if (bus16.StallCount !== 16'd0) begin
            n_bad++; $display("FAIL midop_reset_count got=%0d exp=0", bus16.StallCount);
        end
        @(negedge Clk);
        tick();
        md = 0; Rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            n_cmp++;
            if (outs16() !== 7'b1100000 || bus16.StallCount !== 16'd0) begin
                n_bad++; $display("FAIL midop_after%0d got=%b/%0d exp=%b/0", c, outs16(),
                                  bus16.StallCount, 7'b1100000);
            end
            tick();
        end
        $display("test_reset_mid_op: outs=%b count=%0d", outs16(), bus16.StallCount);
    endtask

    task automatic test_saturation();
        Rst = 1'b1; model_reset();
        tick();
        Rst = 1'b0;
        mem_read = 1; rt_ex = 5'd12; rs_id = 5'd12;
        for (int c = 0; c < 20; c++) tick();
        set_idle();
        #1;
        n_cmp++;
        if (bus4.StallCount !== 4'd15) begin
            n_bad++; $display("FAIL sat_count4 got=%0d exp=15", bus4.StallCount);
        end
        n_cmp++;
        if (bus16.StallCount !== 16'd20) begin
            n_bad++; $display("FAIL sat_count16 got=%0d exp=20", bus16.StallCount);
        end
        $display("test_saturation: cnt4=%0d cnt16=%0d", bus4.StallCount, bus16.StallCount);
        tick();
    endtask

    task automatic test_random();
        logic [6:0] e;
        for (int c = 0; c < 400; c++) begin
            mem_read = ($urandom_range(0, 1) == 1);
            rt_ex    = 5'($urandom_range(0, 3));
            rs_id    = 5'($urandom_range(0, 3));
            rt_id    = 5'($urandom_range(0, 3));
            uses_rt  = ($urandom_range(0, 1) == 1);
            br       = ($urandom_range(0, 7) == 0);
            md       = ($urandom_range(0, 5) == 0);
            #1;
            e = exp_outs();
            n_cmp++;
            if (outs16() !== e || outs4() !== e) begin
                n_bad++; $display("FAIL rand_outs%0d got=%b/%b exp=%b", c, outs16(), outs4(), e);
            end
            n_cmp++;
            if (bus16.StallCount !== 16'(m_cnt16) || bus4.StallCount !== 4'(m_cnt4)) begin
                n_bad++; $display("FAIL rand_count%0d got=%0d/%0d exp=%0d/%0d", c,
                                  bus16.StallCount, bus4.StallCount, m_cnt16, m_cnt4);
            end
            if (c % 50 == 0)
                $display("test_random: cycle %0d outs=%b count=%0d", c, outs16(), bus16.StallCount);
            tick();
        end
        set_idle();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_zero_reg();
        test_branch_hazard();
        test_muldiv();
        test_back_to_back();
        test_reset_mid_op();
        test_saturation();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage MIPS datapath; it drives the stall, flush and hold controls of the IF/ID, ID/EX and EX/MEM pipeline registers. It detects load-use hazards between the EX and ID stages and squashes wrong-path instructions on a taken branch resolved in EX. It also freezes the front end and EX stage for the fixed latency of the multi-cycle mul/div unit, and keeps a saturating stall-cycle counter for performance measurement.

## Interface
Parameters:
- MD_CYCLES, 4, total EX-hold cycles for a mul/div op, including the start cycle; legal range 2..255
- CNT_W, 16, width of StallCount

Ports:
- Clk  in  1  pipeline clock, rising edge
- Rst  in  1  asynchronous, active-high reset
- MemRead_EX  in  1  instruction in EX is a load
- Rt_EX  in  5  destination register of the EX-stage load (Ins20_16_Ex)
- Rs_ID  in  5  rs field of the ID-stage instruction
- Rt_ID  in  5  rt field of the ID-stage instruction
- UsesRt_ID  in  1  ID-stage instruction reads rt
- BranchTaken_EX  in  1  branch in EX resolved as taken
- MulDivStart_EX  in  1  mul/div instruction present in EX
- PCWrite  out  1  PC load enable
- IF_ID_Write  out  1  IF/ID load enable
- IF_ID_Flush  out  1  IF/ID loads a NOP
- ID_EX_Flush  out  1  ID/EX loads a bubble (all controls zero)
- EX_Hold  out  1  ID/EX and EX/MEM keep their current contents
- MulDivDone  out  1  one-cycle pulse on the final hold cycle
- Busy  out  1  FSM is in MD_BUSY
- StallCount  out  CNT_W  count of cycles with PCWrite=0, saturating

## Operation
- Two states: RUN and MD_BUSY. There is an 8-bit down-counter cnt.
- Outputs are combinational (Mealy) from the state, cnt and the current inputs.
- Default output values: PCWrite=1, IF_ID_Write=1, all flushes/holds/pulses 0.
- Load-use hazard is defined as: MemRead_EX && Rt_EX!=0 && (Rt_EX==Rs_ID || (UsesRt_ID && Rt_EX==Rt_ID)).
- RUN, priority order:
  1. BranchTaken_EX: IF_ID_Flush=1, ID_EX_Flush=1, PCWrite=1. Stay in RUN. Any load-use hazard is ignored because the ID instruction is squashed.
  2. MulDivStart_EX: PCWrite=0, IF_ID_Write=0, EX_Hold=1. Load cnt=MD_CYCLES-1 and go to MD_BUSY.
  3. Load-use hazard: PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1. Stay in RUN. The load advances to MEM, so the hazard clears on the next cycle and needs no state.
  4. Otherwise: default values.
- MD_BUSY:
  - Outputs: PCWrite=0, IF_ID_Write=0, EX_Hold=1, Busy=1.
  - BranchTaken_EX and the hazard inputs are ignored.
  - cnt decrements every cycle.
  - When cnt==1: MulDivDone=1 and next state is RUN.
- StallCount:
  - Increments on every clock edge where PCWrite=0.
  - Holds at all-ones (saturates) instead of wrapping.
- Register $zero (Rt_EX==0) never causes a stall.

## Timing
- Reset (asynchronous, takes effect immediately, independent of Clk):
  - state=RUN, cnt=0, StallCount=0.
  - While Rst=1, outputs are forced to PCWrite=0, IF_ID_Write=0, flushes=0, EX_Hold=0, MulDivDone=0, Busy=0.
- Asserting Rst during MD_BUSY aborts the operation. After release the FSM is in RUN with cnt=0 and produces no MulDivDone.
- First post-reset edge: state and counter update on the first rising Clk after Rst deasserts.
- Zero-latency control: outputs respond to input changes in the same cycle. They are sampled by the pipeline registers on the next rising edge.
- Load-use stall length: exactly 1 cycle per hazard. Two back-to-back loads feeding one consumer produce separate one-cycle stalls.
- Mul/div hold: exactly MD_CYCLES consecutive cycles with EX_Hold=1 (the start cycle plus MD_CYCLES-1 cycles in MD_BUSY). The cycle after MulDivDone is RUN with default outputs, unless a new event is present.
- MulDivStart_EX is still asserted on the first RUN cycle after a completed op, because EX_Hold has kept that instruction in EX. It must not retrigger the op: the RUN cycle that immediately follows MD_BUSY ignores MulDivStart_EX. This requires a one-bit just_done flag, cleared by reset.
- Branch taken together with MulDivStart_EX in RUN: the branch wins. No hold is applied and the start is ignored, because a branch and a mul/div cannot occupy EX together and this combination is treated as an illegal input.

## Test plan
- Load-use: MemRead_EX=1, Rt_EX=8, Rs_ID=8 -> exactly one cycle of PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1. StallCount becomes 1.
- Zero register: same as above but Rt_EX=0, Rs_ID=0 -> no stall, default outputs.
- Branch with hazard: BranchTaken_EX=1 together with a load-use match -> IF_ID_Flush=1, ID_EX_Flush=1, PCWrite=1, StallCount unchanged.
- Mul/div with MD_CYCLES=4: MulDivStart_EX held high -> EX_Hold=1 for exactly 4 cycles, MulDivDone pulse on the 4th, Busy=1 on cycles 2-4, no retrigger on the following cycle, StallCount=4.
- Reset mid-op: assert Rst on the 2nd MD_BUSY cycle -> outputs go to their reset values immediately. After release: RUN, StallCount=0, no MulDivDone.
- Saturation with CNT_W=4: hold a continuous stall source for 20 cycles -> StallCount stops at 15.
